// File: rtl/ptosda_pkg.sv
// ---------------------------------------------------------------------------
// ptosda_pkg
// Shared types and constants for the ptosda transmitter arbiter.
//   state_t      : arbiter FSM states
//   NIBBLE_W     : width of one requester payload / transmitter data word
//   DEF_TMO_CYC  : default transmitter handshake timeout, in sclk cycles
//   DEF_GAP_CYC  : default idle gap after a frame, in sclk cycles
//   cnt_width()  : counter width helper that never returns zero
// ---------------------------------------------------------------------------
package ptosda_pkg;

  localparam int NIBBLE_W    = 4;
  localparam int DEF_TMO_CYC = 64;
  localparam int DEF_GAP_CYC = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_START,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  // Width needed to count 0..n-1; a one-value counter still gets one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ptosda_arbiter_if.sv
// ---------------------------------------------------------------------------
// ptosda_arbiter_if
// Bundles the requester side and the transmitter side of the arbiter.
//   req       : level request per requester
//   req_data  : one nibble per requester, slice i = [4i+3:4i]
//   gnt       : one-cycle one-hot accept pulse
//   tx_idle   : transmitter is in its ready state
//   tx_d_ena  : transmitter d_ena
//   tx_data   : transmitter data, stable while tx_d_ena is high
//   busy      : arbiter is not idle
//   last_id   : index of the most recently granted requester
//   err_tmo   : sticky transmitter timeout flag
// Modports: slave = arbiter, master = requesters + transmitter.
// ---------------------------------------------------------------------------
interface ptosda_arbiter_if #(
  parameter int N_REQ = 4
);
  import ptosda_pkg::*;

  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]          req;
  logic [NIBBLE_W*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]          gnt;
  logic                      tx_idle;
  logic                      tx_d_ena;
  logic [NIBBLE_W-1:0]       tx_data;
  logic                      busy;
  logic [ID_W-1:0]           last_id;
  logic                      err_tmo;

  modport slave (
    input  req, req_data, tx_idle,
    output gnt, tx_d_ena, tx_data, busy, last_id, err_tmo
  );

  modport master (
    output req, req_data, tx_idle,
    input  gnt, tx_d_ena, tx_data, busy, last_id, err_tmo
  );

endinterface

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the first set request bit at or
// after ptr, wrapping to bit 0.
//   req    : request vector
//   ptr    : highest-priority index for this pick
//   en     : when low, no winner is produced
//   win    : one-hot winner (all zero when none)
//   win_id : binary index of the winner (zero when none)
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  input  logic            en,
  output logic [N-1:0]    win,
  output logic [ID_W-1:0] win_id
);

  logic [N-1:0] hi_req;
  logic [N-1:0] pick;
  logic         found;

  // Requests at or above the pointer get first chance; the wrap-around is
  // handled by falling back to the full vector when none of those is set.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
      assign hi_req[gi] = req[gi] & (ID_W'(gi) >= ptr);
    end
  endgenerate

  always_comb begin
    pick   = '0;
    win    = '0;
    win_id = '0;
    found  = 1'b0;
    if (en) begin
      pick = (|hi_req) ? hi_req : req;
    end
    for (int k = 0; k < N; k++) begin
      if (!found && pick[k]) begin
        found  = 1'b1;
        win[k] = 1'b1;
        win_id = ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/ptosda_arbiter.sv
// ---------------------------------------------------------------------------
// ptosda_arbiter
// Round-robin scheduler sharing one ptosda serial transmitter between N_REQ
// nibble requesters. A winner's nibble is latched at grant time and held on
// tx_data with tx_d_ena high until the transmitter leaves idle; the arbiter
// then waits for the frame to end and enforces GAP_CYC idle cycles before
// the next grant. A stuck transmitter raises the sticky err_tmo flag.
//   sclk : clock, all logic on posedge
//   rst  : asynchronous active-low reset
//   bus  : requester / transmitter signals (slave side)
// ---------------------------------------------------------------------------
module ptosda_arbiter
  import ptosda_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int GAP_CYC = DEF_GAP_CYC,
  parameter int TMO_CYC = DEF_TMO_CYC
) (
  input  logic               sclk,
  input  logic               rst,
  ptosda_arbiter_if.slave    bus
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int TMR_W = cnt_width(TMO_CYC);
  localparam int GAP_W = cnt_width(GAP_CYC);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TMO_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = '1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

  state_t               state_reg;
  logic [N_REQ-1:0]     gnt_reg;
  logic                 d_ena_reg;
  logic [NIBBLE_W-1:0]  data_reg;
  logic                 busy_reg;
  logic [ID_W-1:0]      last_id_reg;
  logic                 err_tmo_reg;
  logic [ID_W-1:0]      ptr_reg;
  logic [TMR_W-1:0]     timer_reg;
  logic [GAP_W-1:0]     gap_reg;

  logic [NIBBLE_W-1:0]  req_nib [N_REQ];
  logic [N_REQ-1:0]     win;
  logic [ID_W-1:0]      win_id;
  logic                 arb_en;
  logic [ID_W-1:0]      ptr_next;
  logic                 tmo_hit;
  logic [TMR_W-1:0]     timer_inc;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_nib
      assign req_nib[gi] = bus.req_data[gi*NIBBLE_W +: NIBBLE_W];
    end
  endgenerate

  // Arbitration is only meaningful when a grant can actually be issued.
  assign arb_en = (state_reg == S_IDLE) && bus.tx_idle;

  rr_arbiter #(
    .N    (N_REQ),
    .ID_W (ID_W)
  ) u_rr (
    .req    (bus.req),
    .ptr    (ptr_reg),
    .en     (arb_en),
    .win    (win),
    .win_id (win_id)
  );

  assign ptr_next  = (win_id == ID_LAST) ? '0 : win_id + 1'b1;
  assign tmo_hit   = (timer_reg == TMR_LAST);
  // Saturating increment: a timer that never wraps cannot miss the limit.
  assign timer_inc = (timer_reg == TMR_MAX) ? timer_reg : timer_reg + 1'b1;

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      gnt_reg     <= '0;
      d_ena_reg   <= 1'b0;
      data_reg    <= '0;
      busy_reg    <= 1'b0;
      last_id_reg <= '0;
      err_tmo_reg <= 1'b0;
      ptr_reg     <= '0;
      timer_reg   <= '0;
      gap_reg     <= '0;
    end else begin
      gnt_reg <= '0;
      unique case (state_reg)
        S_IDLE: begin
          // win is all-zero unless a request is pending and tx is ready.
          if (|win) begin
            gnt_reg     <= win;
            data_reg    <= req_nib[win_id];
            last_id_reg <= win_id;
            ptr_reg     <= ptr_next;
            busy_reg    <= 1'b1;
            state_reg   <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          d_ena_reg <= 1'b1;
          timer_reg <= '0;
          state_reg <= S_WAIT_START;
        end
        S_WAIT_START: begin
          if (!bus.tx_idle) begin
            d_ena_reg <= 1'b0;
            timer_reg <= '0;
            state_reg <= S_WAIT_DONE;
          end else if (tmo_hit) begin
            err_tmo_reg <= 1'b1;
            d_ena_reg   <= 1'b0;
            gap_reg     <= '0;
            state_reg   <= S_GAP;
          end else begin
            timer_reg <= timer_inc;
          end
        end
        S_WAIT_DONE: begin
          if (bus.tx_idle) begin
            gap_reg   <= '0;
            state_reg <= S_GAP;
          end else if (tmo_hit) begin
            err_tmo_reg <= 1'b1;
            gap_reg     <= '0;
            state_reg   <= S_GAP;
          end else begin
            timer_reg <= timer_inc;
          end
        end
        S_GAP: begin
          if (gap_reg == GAP_LAST) begin
            busy_reg  <= 1'b0;
            state_reg <= S_IDLE;
          end else begin
            gap_reg <= gap_reg + 1'b1;
          end
        end
        default: begin
          d_ena_reg <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt      = gnt_reg;
  assign bus.tx_d_ena = d_ena_reg;
  assign bus.tx_data  = data_reg;
  assign bus.busy     = busy_reg;
  assign bus.last_id  = last_id_reg;
  assign bus.err_tmo  = err_tmo_reg;

endmodule

// File: tb/tb_ptosda_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ptosda_arbiter
// Scoreboarded bench for ptosda_arbiter. Expected grants (requester id and
// nibble) are queued by each scenario task; a monitor pops them on every
// gnt pulse and checks id, last_id, one-hotness, d_ena latency, held
// tx_data and the post-frame gap. A small transmitter model answers
// tx_d_ena (normal), stays idle forever (dead) or follows a task (manual).
// ---------------------------------------------------------------------------
module tb_ptosda_arbiter;
  import ptosda_pkg::*;

  localparam int N_REQ   = 4;
  localparam int GAP_CYC = 2;
  localparam int TMO_CYC = 64;

  localparam int M_NORMAL = 0;
  localparam int M_DEAD   = 1;
  localparam int M_MANUAL = 2;

  typedef struct {
    int         id;
    logic [3:0] data;
  } exp_t;

  logic sclk = 1'b0;
  logic rst  = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   mode   = M_NORMAL;
  logic manual_idle = 1'b1;
  exp_t sb[$];

  always #5 sclk = ~sclk;

  ptosda_arbiter_if #(.N_REQ(N_REQ)) bus ();

  ptosda_arbiter #(
    .N_REQ   (N_REQ),
    .GAP_CYC (GAP_CYC),
    .TMO_CYC (TMO_CYC)
  ) dut (
    .sclk (sclk),
    .rst  (rst),
    .bus  (bus)
  );

  initial begin : cyc_counter
    forever begin
      @(posedge sclk);
      cyc++;
    end
  end

  // Transmitter model; updates 2ns after the falling edge so the monitor
  // always samples a settled value.
  initial begin : tx_model
    int phase;
    int cnt;
    phase = 0;
    cnt   = 0;
    bus.tx_idle = 1'b1;
    forever begin
      @(negedge sclk);
      #2;
      if (mode == M_DEAD) begin
        bus.tx_idle = 1'b1;
        phase = 0;
      end else if (mode == M_MANUAL) begin
        bus.tx_idle = manual_idle;
        phase = 0;
      end else begin
        case (phase)
          0: if (bus.tx_d_ena === 1'b1) begin phase = 1; cnt = 0; end
          1: begin
            cnt++;
            if (cnt == 3) begin bus.tx_idle = 1'b0; phase = 2; cnt = 0; end
          end
          default: begin
            cnt++;
            if (cnt == 12) begin bus.tx_idle = 1'b1; phase = 0; end
          end
        endcase
      end
    end
  end

  // Scoreboard monitor.
  initial begin : monitor
    exp_t       e;
    logic [3:0] cur_data;
    bit         cur_valid, prev_gnt, prev_dena, prev_idle, done_valid;
    int         done_cyc;
    cur_data = '0; cur_valid = 0; prev_gnt = 0; prev_dena = 0;
    prev_idle = 1; done_valid = 0; done_cyc = 0;
    forever begin
      @(negedge sclk);
      if (!rst) begin
        cur_valid = 0; prev_gnt = 0; prev_dena = 0; done_valid = 0;
        prev_idle = bus.tx_idle;
      end else begin
        if (bus.gnt !== '0) begin
          checks++;
          if (!$onehot(bus.gnt)) begin
            errors++;
            $display("FAIL gnt_onehot: got %b required one-hot", bus.gnt);
          end
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL gnt_unexpected: got %b required no grant", bus.gnt);
          end else begin
            e = sb.pop_front();
            checks++;
            if (bus.gnt !== (N_REQ'(1) << e.id)) begin
              errors++;
              $display("FAIL gnt_id: got %b required bit %0d", bus.gnt, e.id);
            end
            checks++;
            if (bus.last_id !== 2'(e.id)) begin
              errors++;
              $display("FAIL last_id: got %0d required %0d", bus.last_id, e.id);
            end
            cur_data  = e.data;
            cur_valid = 1;
            if (done_valid) begin
              checks++;
              if (cyc - done_cyc < GAP_CYC + 1) begin
                errors++;
                $display("FAIL gap: got %0d cycles required >= %0d", cyc - done_cyc, GAP_CYC + 1);
              end
            end
          end
          done_valid = 0;
        end
        if (bus.tx_d_ena === 1'b1) begin
          if (!prev_dena) begin
            checks++;
            if (!prev_gnt) begin
              errors++;
              $display("FAIL dena_latency: d_ena rose without gnt one cycle earlier");
            end
          end
          checks++;
          if (!cur_valid || bus.tx_data !== cur_data) begin
            errors++;
            $display("FAIL tx_data: got %h required %h", bus.tx_data, cur_data);
          end
        end
        if (bus.tx_idle === 1'b1 && !prev_idle && bus.busy === 1'b1) begin
          done_cyc   = cyc;
          done_valid = 1;
        end
        prev_idle = bus.tx_idle;
        prev_dena = (bus.tx_d_ena === 1'b1);
        prev_gnt  = (bus.gnt !== '0);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_not_busy(output bit ok);
    ok = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge sclk);
      if (bus.busy === 1'b0) begin ok = 1; break; end
    end
  endtask

  task automatic wait_gnt(input int idx, output bit ok);
    ok = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge sclk);
      if (bus.gnt[idx] === 1'b1) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    bit ok;
    rst = 1'b0;
    bus.req = '0;
    bus.req_data = '0;
    repeat (3) @(negedge sclk);
    checks++;
    if ({bus.gnt, bus.tx_d_ena, bus.tx_data, bus.busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got gnt=%b dena=%b data=%h busy=%b required 0",
               bus.gnt, bus.tx_d_ena, bus.tx_data, bus.busy);
    end
    checks++;
    if ({bus.last_id, bus.err_tmo} !== '0) begin
      errors++;
      $display("FAIL reset_status: got last_id=%0d err_tmo=%b required 0", bus.last_id, bus.err_tmo);
    end
    rst = 1'b1;
    repeat (2) @(negedge sclk);
    checks++;
    if (bus.busy !== 1'b0 || bus.gnt !== '0) begin
      errors++;
      $display("FAIL reset_release: got busy=%b gnt=%b required 0", bus.busy, bus.gnt);
    end
    ok = 1;
  endtask

  // Lone requester 1, held for two frames: re-granted after the gap.
  task automatic test_single();
    int n;
    bit ok;
    mode = M_NORMAL;
    bus.req_data = 16'h00A0;
    sb.push_back('{id: 1, data: 4'hA});
    sb.push_back('{id: 1, data: 4'hA});
    bus.req = 4'b0010;
    n = 0;
    for (int c = 0; c < 300 && n < 2; c++) begin
      @(negedge sclk);
      if (bus.gnt[1] === 1'b1) begin
        n++;
        if (n == 2) bus.req = '0;
      end
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL single_grants: got %0d grants required 2", n);
    end
    wait_not_busy(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_done: busy stuck high"); end
  endtask

  // All four requesting after reset: order 0,1,2,3,0.
  task automatic test_round_robin();
    int n;
    bit ok;
    @(negedge sclk);
    rst = 1'b0;
    repeat (2) @(negedge sclk);
    rst = 1'b1;
    bus.req_data = 16'h4321;
    sb.push_back('{id: 0, data: 4'h1});
    sb.push_back('{id: 1, data: 4'h2});
    sb.push_back('{id: 2, data: 4'h3});
    sb.push_back('{id: 3, data: 4'h4});
    sb.push_back('{id: 0, data: 4'h1});
    bus.req = 4'b1111;
    n = 0;
    for (int c = 0; c < 600 && n < 5; c++) begin
      @(negedge sclk);
      if (bus.gnt !== '0) begin
        n++;
        if (n == 5) bus.req = '0;
      end
    end
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL rr_grants: got %0d grants required 5", n);
    end
    wait_not_busy(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rr_done: busy stuck high"); end
  endtask

  // Request while the transmitter is not idle must wait.
  task automatic test_idle_block();
    bit ok;
    mode = M_MANUAL;
    manual_idle = 1'b0;
    repeat (2) @(negedge sclk);
    bus.req_data = 16'h0700;
    sb.push_back('{id: 2, data: 4'h7});
    bus.req = 4'b0100;
    for (int c = 0; c < 8; c++) begin
      @(negedge sclk);
      checks++;
      if (bus.gnt !== '0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_block: got gnt=%b busy=%b required 0 while tx busy", bus.gnt, bus.busy);
      end
    end
    manual_idle = 1'b1;
    @(negedge sclk);
    checks++;
    if (bus.gnt !== 4'b0100) begin
      errors++;
      $display("FAIL idle_release: got gnt=%b required 0100", bus.gnt);
    end
    bus.req = '0;
    mode = M_NORMAL;
    wait_not_busy(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL idle_done: busy stuck high"); end
  endtask

  // Requester drops and changes data right after its grant.
  task automatic test_drop_after_gnt();
    bit ok;
    mode = M_NORMAL;
    bus.req_data = 16'h5000;
    sb.push_back('{id: 3, data: 4'h5});
    bus.req = 4'b1000;
    wait_gnt(3, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL drop_gnt: no grant to requester 3"); end
    @(negedge sclk);
    bus.req = '0;
    bus.req_data = 16'hF000;
    for (int c = 0; c < 6; c++) begin
      @(negedge sclk);
      if (bus.tx_d_ena === 1'b1) begin
        checks++;
        if (bus.tx_data !== 4'h5) begin
          errors++;
          $display("FAIL drop_data: got %h required 5", bus.tx_data);
        end
      end
    end
    wait_not_busy(ok);
    checks++;
    if (!ok || bus.last_id !== 2'd3) begin
      errors++;
      $display("FAIL drop_done: got busy_ok=%0d last_id=%0d required 1 and 3", ok, bus.last_id);
    end
  endtask

  // Dead transmitter: timeout after TMO_CYC cycles, then gap back to idle.
  task automatic test_timeout();
    bit ok;
    int t0, t1;
    mode = M_DEAD;
    bus.req_data = 16'h0009;
    sb.push_back('{id: 0, data: 4'h9});
    bus.req = 4'b0001;
    wait_gnt(0, ok);
    bus.req = '0;
    checks++;
    if (!ok) begin errors++; $display("FAIL tmo_gnt: no grant to requester 0"); end
    t0 = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge sclk);
      if (bus.tx_d_ena === 1'b1) begin t0 = cyc; break; end
    end
    t1 = -1;
    for (int c = 0; c < 200; c++) begin
      @(negedge sclk);
      if (bus.err_tmo === 1'b1) begin t1 = cyc; break; end
    end
    checks++;
    if (t0 < 0 || t1 < 0 || t1 - t0 != TMO_CYC) begin
      errors++;
      $display("FAIL tmo_latency: got %0d cycles required %0d", t1 - t0, TMO_CYC);
    end
    checks++;
    if (bus.tx_d_ena !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL tmo_state: got dena=%b busy=%b required 0 and 1", bus.tx_d_ena, bus.busy);
    end
    repeat (GAP_CYC - 1) @(negedge sclk);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL tmo_gap: got busy=%b required 1 during gap", bus.busy);
    end
    @(negedge sclk);
    checks++;
    if (bus.busy !== 1'b0 || bus.err_tmo !== 1'b1) begin
      errors++;
      $display("FAIL tmo_end: got busy=%b err_tmo=%b required 0 and 1", bus.busy, bus.err_tmo);
    end
    mode = M_NORMAL;
  endtask

  // Reset while the frame is on the wire, then a fresh grant.
  task automatic test_reset_mid_frame();
    bit ok;
    mode = M_NORMAL;
    bus.req_data = 16'h00C0;
    sb.push_back('{id: 1, data: 4'hC});
    bus.req = 4'b0010;
    wait_gnt(1, ok);
    bus.req = '0;
    ok = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge sclk);
      if (bus.tx_idle === 1'b0) begin ok = 1; break; end
    end
    repeat (2) @(negedge sclk);
    checks++;
    if (!ok || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_frame: got started=%0d busy=%b required 1 and 1", ok, bus.busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.gnt, bus.tx_d_ena, bus.tx_data, bus.busy, bus.last_id, bus.err_tmo} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got gnt=%b dena=%b data=%h busy=%b id=%0d err=%b required 0",
               bus.gnt, bus.tx_d_ena, bus.tx_data, bus.busy, bus.last_id, bus.err_tmo);
    end
    sb.delete();
    mode = M_MANUAL;
    manual_idle = 1'b1;
    repeat (2) @(negedge sclk);
    rst = 1'b1;
    bus.req_data = 16'h0E00;
    sb.push_back('{id: 2, data: 4'hE});
    bus.req = 4'b0100;
    wait_gnt(2, ok);
    bus.req = '0;
    mode = M_NORMAL;
    checks++;
    if (!ok) begin errors++; $display("FAIL post_reset_gnt: no grant to requester 2"); end
    wait_not_busy(ok);
    checks++;
    if (!ok || bus.last_id !== 2'd2) begin
      errors++;
      $display("FAIL post_reset_done: got busy_ok=%0d last_id=%0d required 1 and 2", ok, bus.last_id);
    end
  endtask

  initial begin : main
    test_reset();
    test_single();
    test_round_robin();
    test_idle_block();
    test_drop_after_gnt();
    test_timeout();
    test_reset_mid_frame();
    repeat (5) @(negedge sclk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d pending grants required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
